demux2_stream: RTL

//  Registered 1-to-2 stream demultiplexer, the inverse of the mux5 selector.

---
 rtl/demux2_stream.sv | 100 ++++++++++
 1 files changed

// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 stream demultiplexer.
// Each input word goes to out0 or out1, chosen by sel.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   sel               destination of current word (0 -> out0, 1 -> out1)
//   in_valid/in_data  input stream word
//   in_ready          input word accepted when in_valid && in_ready
//   outN_valid/data   held word for sink N (one-entry register)
//   outN_ready        sink N takes the held word this cycle
//   cntN              words accepted for output N (wraps)
module demux2_stream #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out0_data,
    input  logic             out0_ready,
    output logic             out1_valid,
    output logic [WIDTH-1:0] out1_data,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             r_v0;
    logic             r_v1;
    logic [WIDTH-1:0] r_d0;
    logic [WIDTH-1:0] r_d1;
    logic [CNT_W-1:0] r_c0;
    logic [CNT_W-1:0] r_c1;

    logic w_free0;
    logic w_free1;
    logic w_pop0;
    logic w_pop1;
    logic w_push0;
    logic w_push1;

    // A channel can take a word when empty or when its word leaves now.
    assign w_free0 = !r_v0 || out0_ready;
    assign w_free1 = !r_v1 || out1_ready;

    // Only the selected channel gates acceptance, so a stalled
    // channel never blocks traffic headed for the other one.
    assign in_ready = !rst && (sel ? w_free1 : w_free0);

    assign w_pop0  = r_v0 && out0_ready;
    assign w_pop1  = r_v1 && out1_ready;
    assign w_push0 = in_valid && in_ready && !sel;
    assign w_push1 = in_valid && in_ready && sel;

    // Channel 0: a push wins over a pop, giving bubble-free streaming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_d0 <= '0;
            r_c0 <= '0;
        end else begin
            if (w_push0) begin
                r_v0 <= 1'b1;
                r_d0 <= in_data;
                r_c0 <= r_c0 + CNT_W'(1);
            end else if (w_pop0) begin
                r_v0 <= 1'b0;
            end
        end
    end

    // Channel 1: same rules as channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_d1 <= '0;
            r_c1 <= '0;
        end else begin
            if (w_push1) begin
                r_v1 <= 1'b1;
                r_d1 <= in_data;
                r_c1 <= r_c1 + CNT_W'(1);
            end else if (w_pop1) begin
                r_v1 <= 1'b0;
            end
        end
    end

    assign out0_valid = r_v0;
    assign out0_data  = r_d0;
    assign out1_valid = r_v1;
    assign out1_data  = r_d1;
    assign cnt0       = r_c0;
    assign cnt1       = r_c1;

endmodule
